// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the two-port cache arbiter.
// Latency: none (types only).
// Backpressure: not applicable.
package cache_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Port 0 is the fetch side, port 1 the data side.
    typedef logic port_idx_t;

    function automatic logic [1:0] port_mask(input port_idx_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Requester and cache-side signals of the cache arbiter; slave is the arbiter view.
// Latency: none (wiring only).
// Backpressure: cache_rdy from the cache; requesters hold until ack.
interface cache_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [1:0]        req_ren;
    logic [1:0]        req_wen;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_din0;
    logic [DATA_W-1:0] req_din1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              cache_rdy;

    modport slave (
        input  req_ren, req_wen, req_addr0, req_addr1, req_din0, req_din1, dout, cache_rdy,
        output ack, rdata, err, ren, wen, addr, din
    );

    modport master (
        output req_ren, req_wen, req_addr0, req_addr1, req_din0, req_din1, dout, cache_rdy,
        input  ack, rdata, err, ren, wen, addr, din
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational 2-way picker: the pointed port wins when both request.
// Latency: 0 cycles.
// Backpressure: none; vld low when nothing requests.
module arb_pick
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  ptr,
    output port_idx_t  idx,
    output logic       vld
);

    assign vld = |req;
    assign idx = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/cache_arbiter.sv
// Two-port cache arbiter with WAIT timeout; CACHE_ARB_RR_EN selects round-robin, else port 0 priority.
// Latency: sample, strobe, complete, then ack in DONE (3 cycles + DONE minimum).
// Backpressure: stalls in IDLE/WAIT while cache_rdy is low; requesters hold until ack.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TMO_CYC = 255
) (
    input  logic           clk,
    input  logic           rst,
    cache_arbiter_if.slave bus
);

    localparam logic [8:0] TMO_LAST = 9'(TMO_CYC - 1);

    state_t            state_q, state_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [8:0]        cnt_q, cnt_d;
    port_idx_t         gnt_q, gnt_d;
    logic [1:0]        req;
    port_idx_t         ptr;
    port_idx_t         pick_idx;
    logic              pick_vld;

    assign req = bus.req_ren | bus.req_wen;

    arb_pick u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

`ifdef CACHE_ARB_RR_EN
    port_idx_t ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if ((state_q == IDLE) && (state_d == WAIT)) begin
            ptr_q <= ~pick_idx;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = 2'b00;
        rdata_d = rdata_q;
        err_d   = err_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                // A live ack here is a timeout the requester has not yet dropped for.
                if (bus.cache_rdy && pick_vld && (ack_q == 2'b00)) begin
                    gnt_d   = pick_idx;
                    addr_d  = pick_idx ? bus.req_addr1 : bus.req_addr0;
                    din_d   = pick_idx ? bus.req_din1 : bus.req_din0;
                    wen_d   = bus.req_wen[pick_idx];
                    ren_d   = ~bus.req_wen[pick_idx];
                    cnt_d   = 9'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The strobe cycle is recognised by the registered ren/wen pulse.
                if (!(ren_q || wen_q) && bus.cache_rdy) begin
                    ack_d   = port_mask(gnt_q);
                    rdata_d = bus.dout;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    ack_d   = port_mask(gnt_q);
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 2'b00;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            cnt_q   <= 9'd0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.ren   = ren_q;
    assign bus.wen   = wen_q;
    assign bus.addr  = addr_q;
    assign bus.din   = din_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cache_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int          m_ptr = 0;
    logic        m_err = 1'b0;
    logic [1:0]  r_ren;
    logic [1:0]  r_wen;
    logic [31:0] r_addr [2];
    logic [31:0] r_din  [2];

    cache_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.req_ren   = r_ren;
        bus.req_wen   = r_wen;
        bus.req_addr0 = r_addr[0];
        bus.req_addr1 = r_addr[1];
        bus.req_din0  = r_din[0];
        bus.req_din1  = r_din[1];
    endtask

    task automatic grant_model(input int w);
`ifdef CACHE_ARB_RR_EN
        m_ptr = 1 - w;
`else
        m_ptr = 0 * w;
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   bus.ack,   2'b00);
        chk({tag, "_ren"},   bus.ren,   1'b0);
        chk({tag, "_wen"},   bus.wen,   1'b0);
        chk({tag, "_err"},   bus.err,   1'b0);
        chk({tag, "_rdata"}, bus.rdata, 32'h0);
        chk({tag, "_addr"},  bus.addr,  32'h0);
        chk({tag, "_din"},   bus.din,   32'h0);
    endtask

    task automatic do_reset(input string tag);
        bus.cache_rdy = 1'b0;
        rst = 1'b1;
        step();
        chk_all_zero(tag);
        step();
        rst   = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    // One complete access for the port the model expects to win.
    task automatic serve(input int pre, input int delay, input logic [31:0] dval);
        logic [1:0]  req;
        int          w;
        logic        wr;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [1:0]  em;
        req = r_ren | r_wen;
        for (int i = 0; i < pre; i++) begin
            bus.cache_rdy = 1'b0;
            step();
            chk("stall_no_strobe", {bus.ren, bus.wen}, 2'b00);
        end
        w  = req[m_ptr] ? m_ptr : 1 - m_ptr;
        wr = r_wen[w];
        ea = r_addr[w];
        ed = r_din[w];
        em = (w == 0) ? 2'b01 : 2'b10;
        bus.cache_rdy = 1'b1;
        bus.dout      = $urandom;
        step();
        chk("grant_ren",  bus.ren,  !wr);
        chk("grant_wen",  bus.wen,  wr);
        chk("grant_addr", bus.addr, ea);
        chk("grant_din",  bus.din,  ed);
        chk("grant_ack",  bus.ack,  2'b00);
        grant_model(w);
        bus.cache_rdy = 1'b1;
        step();
        chk("single_strobe", {bus.ren, bus.wen}, 2'b00);
        chk("strobe_rdy_ignored", bus.ack, 2'b00);
        for (int i = 0; i < delay; i++) begin
            bus.cache_rdy = 1'b0;
            bus.dout      = $urandom;
            step();
            chk("wait_no_ack", bus.ack, 2'b00);
            chk("wait_addr_held", bus.addr, ea);
        end
        bus.cache_rdy = 1'b1;
        bus.dout      = dval;
        step();
        chk("done_ack", bus.ack, em);
        if (!wr) chk("done_rdata", bus.rdata, dval);
        chk("done_addr_held", bus.addr, ea);
        chk("done_din_held",  bus.din,  ed);
        chk("done_err", bus.err, m_err);
        r_ren[w] = 1'b0;
        r_wen[w] = 1'b0;
        apply();
        bus.cache_rdy = 1'($urandom);
        bus.dout      = $urandom;
        step();
        chk("ack_one_cycle", bus.ack, 2'b00);
        chk("idle_no_strobe", {bus.ren, bus.wen}, 2'b00);
    endtask

    initial begin
        int early;
        r_ren  = 2'b00;
        r_wen  = 2'b00;
        r_addr[0] = '0; r_addr[1] = '0;
        r_din[0]  = '0; r_din[1]  = '0;
        apply();
        bus.cache_rdy = 1'b0;
        bus.dout      = '0;
        rst           = 1'b1;

        do_reset("reset");

        // Port 0 read with a pre-stall and a slow cache.
        r_ren[0] = 1'b1; r_addr[0] = 32'hace12000; r_din[0] = $urandom;
        apply();
        serve(1, 4, 32'hc0ffee01);

        // Simultaneous port 0 read and port 1 write from a fresh pointer, port 0 re-requesting.
        do_reset("reset2");
        r_ren[0] = 1'b1; r_addr[0] = 32'hace12004; r_din[0] = 32'h0;
        r_wen[1] = 1'b1; r_addr[1] = 32'hdeadbeef; r_din[1] = 32'h12345678;
        apply();
        for (int i = 0; i < 3; i++) begin
            if (!(r_ren[0] || r_wen[0])) begin
                r_ren[0]  = 1'b1;
                r_addr[0] = 32'hace12004 + 32'(4 * i);
            end
            apply();
            serve(0, i, $urandom);
        end
        for (int k = 0; k < 2 && (r_ren | r_wen) != 2'b00; k++) serve(0, 0, $urandom);

        // Read and write together on port 1 is a write.
        r_ren[1] = 1'b1; r_wen[1] = 1'b1; r_addr[1] = 32'haaaaa000; r_din[1] = 32'h5a5a5a5a;
        apply();
        serve(0, 2, $urandom);

        for (int it = 0; it < 24; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(r_ren[p] || r_wen[p]) && $urandom_range(0, 1) == 1) begin
                    int op;
                    op        = $urandom_range(0, 2);
                    r_ren[p]  = (op != 1);
                    r_wen[p]  = (op != 0);
                    r_addr[p] = $urandom;
                    r_din[p]  = $urandom;
                end
            end
            if ((r_ren | r_wen) == 2'b00) begin
                r_ren[0]  = 1'b1;
                r_addr[0] = $urandom;
            end
            apply();
            serve($urandom_range(0, 2), $urandom_range(0, 5), $urandom);
        end
        for (int k = 0; k < 2 && (r_ren | r_wen) != 2'b00; k++) serve(0, 0, $urandom);

        // Cache never answers: timeout, sticky err, zero read data.
        r_ren[0] = 1'b1; r_wen[0] = 1'b0; r_addr[0] = $urandom;
        apply();
        bus.cache_rdy = 1'b1;
        step();
        chk("tmo_strobe", bus.ren, 1'b1);
        grant_model(0);
        bus.cache_rdy = 1'b0;
        early = 0;
        for (int i = 0; i < TMO - 1; i++) begin
            bus.dout = $urandom | 32'h1;
            step();
            if (bus.ack !== 2'b00 || bus.err !== 1'b0) early++;
        end
        chk("tmo_not_early", early, 0);
        step();
        chk("tmo_ack",   bus.ack,   2'b01);
        chk("tmo_err",   bus.err,   1'b1);
        chk("tmo_rdata", bus.rdata, 32'h0);
        m_err    = 1'b1;
        r_ren[0] = 1'b0;
        apply();
        step();
        chk("tmo_ack_clear", bus.ack, 2'b00);
        chk("err_sticky",    bus.err, 1'b1);

        r_wen[1] = 1'b1; r_addr[1] = $urandom; r_din[1] = $urandom;
        apply();
        serve(0, 1, $urandom);

        // Reset two cycles into WAIT abandons the access; the port retries.
        r_ren[1] = 1'b1; r_wen[1] = 1'b0; r_addr[1] = $urandom;
        apply();
        bus.cache_rdy = 1'b1;
        step();
        chk("rst_wait_strobe", bus.ren, 1'b1);
        bus.cache_rdy = 1'b0;
        step();
        step();
        do_reset("rst_mid_wait");
        serve(0, 1, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
